cpu_term_sync: RTL
==================

# cpu_term_sync

Termination front end for the DMAC's CPU-side bus state machine. It samples the 68030 cycle-termination inputs (DSACK0_, DSACK1_, STERM_) and the address strobe. It produces the clean, per-cycle-qualified DSACK and STERM_ terms that the next-state logic consumes, plus a port-size flag and an optional bus-timeout error. One instance sits directly upstream of the CPU state-machine next-state decode.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT without termination before BERR_TO fires; range 2..255, 8-bit counter.
- CLK  input  1  state-machine clock; all flops on rising edge.
- RST  input  1  asynchronous, active-high reset.
- AS_  input  1  address strobe, active low, CLK-synchronous (driven by DMAC).
- DSACK0_  input  1  async data/size ack bit 0, active low.
- DSACK1_  input  1  async data/size ack bit 1, active low.
- STERM_IN_  input  1  synchronous termination, active low, setup-valid to CLK.
- DSACK  output  1  registered: asynchronous termination accepted for current cycle.
- STERM_  output  1  registered, active low: synchronous termination accepted.
- PORT16  output  1  registered: termination was DSACK1_ only (16-bit port).
- TERM_DONE  output  1  one-cycle pulse on the cycle termination is accepted.
- BERR_TO  output  1  timeout error (only with CPU_TERM_TIMEOUT_EN).

## Operation
- Reset values: DSACK=0, STERM_=1, PORT16=0, TERM_DONE=0, BERR_TO=0, state IDLE, sync flops cleared to negated (DSACK sync stages =1), counter=0.
- DSACK0_/DSACK1_ pass a 2-flop synchronizer. A sample counts as asserted only when both synced bits agree on two consecutive CLK edges, which filters single-cycle skew between the bits.
- STERM_IN_ is sampled by one flop with no filter.
- States:
  - IDLE: outputs negated. AS_ sampled low -> WAIT.
  - WAIT: STERM_IN_ sampled low -> TERM with STERM_=0. Otherwise filtered DSACK asserted -> TERM with DSACK=1 and PORT16 = (DSACK1 asserted & DSACK0 negated). AS_ sampled high with no termination -> IDLE (aborted cycle, no pulse).
  - TERM: TERM_DONE=1 for exactly this one cycle -> HOLD.
  - HOLD: DSACK/STERM_/PORT16 stay latched. Leave when AS_ is high and both synced DSACK bits are negated -> IDLE, with outputs clearing on that edge.
- Simultaneous STERM and DSACK in WAIT: STERM wins. DSACK stays 0 and PORT16 stays 0.
- Only one termination is accepted per AS_ cycle. Re-assertion during HOLD is ignored.
- DSACK0_ alone asserted counts as a 32-bit ack: DSACK=1, PORT16=0.
- A new AS_ falling edge while still in HOLD (DSACK bits not yet negated) is deferred. WAIT is entered only after the HOLD exit conditions are met and AS_ is low again.
- RST asserted mid-cycle forces the reset values immediately (asynchronously). Nothing is resumed after release.

## Timing
- STERM_IN_ low at edge N -> STERM_ low and state TERM after edge N+1. TERM_DONE is high for the cycle following edge N+1.
- DSACK edge before edge N -> sync valid at N+1, filter confirms at N+2, DSACK=1 after N+3. Asynchronous termination therefore costs 3 cycles.
- TERM_DONE width is always exactly 1 CLK.
- HOLD-to-IDLE exit is 1 edge after the exit condition is sampled.

## Configuration
- CPU_TERM_TIMEOUT_EN defined:
  - 8-bit counter clears on WAIT entry and increments each cycle in WAIT.
  - Reaching TIMEOUT_CYCLES -> BERR_TO=1 and state HOLD, with no TERM_DONE pulse.
  - BERR_TO clears on HOLD exit.
  - A termination on the same edge as the timeout wins; BERR_TO stays 0.
- Not defined: no counter; BERR_TO tied 0; WAIT holds indefinitely.

## Structure
- Shared CPU state-machine package holds the state enum (IDLE, WAIT, TERM, HOLD) and the default TIMEOUT_CYCLES constant.
- One sub-module, sync2: 2-flop synchronizer with async active-high reset and a parameterized reset value. Instantiate it once per DSACK bit.

## Test plan
- STERM fast cycle: AS_ low, STERM_IN_ low at edge 3 -> STERM_=0 after edge 4, TERM_DONE pulse in cycle 5, DSACK=0; AS_ high plus DSACKs negated -> IDLE and STERM_=1.
- 16-bit ack: DSACK1_=0, DSACK0_=1 asynchronously -> DSACK=1 and PORT16=1 three edges later, with a single TERM_DONE pulse.
- Skewed DSACK: DSACK0_ low one cycle before DSACK1_ -> exactly one acceptance with PORT16=0; no 16-bit ack decoded.
- Simultaneous STERM_IN_ and DSACK in WAIT -> STERM_=0, DSACK=0, PORT16=0.
- Timeout (macro on, TIMEOUT_CYCLES=4): AS_ low with no termination -> BERR_TO=1 after 4 WAIT cycles with no TERM_DONE; same run with macro off -> BERR_TO stays 0 for 300 cycles.
- Reset mid-HOLD: RST pulse while DSACK=1 -> all outputs at reset values before the next CLK edge; state IDLE after release.

Source files
------------

// File: rtl/cpu_term_sync_pkg.sv
// Shared CPU bus state-machine definitions: state encoding and default timeout.
package cpu_term_sync_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TERM = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/cpu_term_sync_sync2.sv
// Two-flop synchronizer with async active-high reset to a configurable value.
module cpu_term_sync_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/cpu_term_sync.sv
// 68030 cycle-termination front end: qualifies DSACK/STERM once per AS_ cycle.
// Optional bus timeout (BERR_TO) is built only when CPU_TERM_TIMEOUT_EN is defined.
module cpu_term_sync
  import cpu_term_sync_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_as_n,
  input  logic i_dsack0_n,
  input  logic i_dsack1_n,
  input  logic i_sterm_in_n,
  output logic o_dsack,
  output logic o_sterm_n,
  output logic o_port16,
  output logic o_term_done,
  output logic o_berr_to
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_ds0_s;
  logic w_ds1_s;
  logic r_ds0_p;
  logic r_ds1_p;
  logic r_sterm_s;

  logic r_dsack,     w_dsack_nxt;
  logic r_sterm_n,   w_sterm_n_nxt;
  logic r_port16,    w_port16_nxt;
  logic r_term_done, w_term_done_nxt;

  logic w_filt_ok;
  logic w_ds_neg;

  cpu_term_sync_sync2 #(.RST_VAL(1'b1)) u_sync_ds0 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_dsack0_n),
    .o_q   (w_ds0_s)
  );

  cpu_term_sync_sync2 #(.RST_VAL(1'b1)) u_sync_ds1 (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_dsack1_n),
    .o_q   (w_ds1_s)
  );

  // Previous synced pair; an ack counts only when the pair is stable across two edges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ds0_p   <= 1'b1;
      r_ds1_p   <= 1'b1;
      r_sterm_s <= 1'b1;
    end else begin
      r_ds0_p   <= w_ds0_s;
      r_ds1_p   <= w_ds1_s;
      r_sterm_s <= i_sterm_in_n;
    end
  end

  assign w_filt_ok = (w_ds0_s == r_ds0_p) && (w_ds1_s == r_ds1_p) && !(w_ds0_s && w_ds1_s);
  assign w_ds_neg  = w_ds0_s && w_ds1_s;

`ifdef CPU_TERM_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_berr;
  logic       w_berr_nxt;
  logic       w_to_hit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 8'd0;
    end else if (r_state != S_WAIT) begin
      r_cnt <= 8'd0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Counter starts at 0 on WAIT entry, so the last WAIT cycle sees TIMEOUT_CYCLES-1.
  assign w_to_hit  = (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign o_berr_to = r_berr;
`else
  logic [7:0] w_unused_to;
  assign w_unused_to = 8'(TIMEOUT_CYCLES);
  assign o_berr_to   = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_dsack_nxt     = r_dsack;
    w_sterm_n_nxt   = r_sterm_n;
    w_port16_nxt    = r_port16;
    w_term_done_nxt = 1'b0;
`ifdef CPU_TERM_TIMEOUT_EN
    w_berr_nxt      = r_berr;
`endif
    case (r_state)
      S_IDLE: begin
        if (!i_as_n) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!r_sterm_s) begin
          w_state_nxt     = S_TERM;
          w_sterm_n_nxt   = 1'b0;
          w_term_done_nxt = 1'b1;
        end else if (w_filt_ok) begin
          w_state_nxt     = S_TERM;
          w_dsack_nxt     = 1'b1;
          w_port16_nxt    = !w_ds1_s && w_ds0_s;
          w_term_done_nxt = 1'b1;
        end else if (i_as_n) begin
          w_state_nxt = S_IDLE;
`ifdef CPU_TERM_TIMEOUT_EN
        end else if (w_to_hit) begin
          w_state_nxt = S_HOLD;
          w_berr_nxt  = 1'b1;
`endif
        end
      end
      S_TERM: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (i_as_n && w_ds_neg) begin
          w_state_nxt   = S_IDLE;
          w_dsack_nxt   = 1'b0;
          w_sterm_n_nxt = 1'b1;
          w_port16_nxt  = 1'b0;
`ifdef CPU_TERM_TIMEOUT_EN
          w_berr_nxt    = 1'b0;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_dsack     <= 1'b0;
      r_sterm_n   <= 1'b1;
      r_port16    <= 1'b0;
      r_term_done <= 1'b0;
`ifdef CPU_TERM_TIMEOUT_EN
      r_berr      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_dsack     <= w_dsack_nxt;
      r_sterm_n   <= w_sterm_n_nxt;
      r_port16    <= w_port16_nxt;
      r_term_done <= w_term_done_nxt;
`ifdef CPU_TERM_TIMEOUT_EN
      r_berr      <= w_berr_nxt;
`endif
    end
  end

  assign o_dsack     = r_dsack;
  assign o_sterm_n   = r_sterm_n;
  assign o_port16    = r_port16;
  assign o_term_done = r_term_done;

endmodule
